// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack datapath memories.
// Used by register16, ram8 and the ram8 bus interface.
package hack_pkg;

    typedef logic [15:0] word_t;
    typedef logic [2:0]  ram8_addr_t;

    localparam int    RAM8_DEPTH = 8;
    localparam word_t WORD_RESET = 16'h0000;

endpackage

// File: rtl/ram8_if.sv
// Data/address bus of the eight-word RAM tile.
// The master drives write data, enable and address; the slave returns the read word.
interface ram8_if;
    import hack_pkg::*;

    word_t      in;
    logic       load;
    ram8_addr_t address;
    word_t      out;

    modport master (
        output in,
        output load,
        output address,
        input  out
    );

    modport slave (
        input  in,
        input  load,
        input  address,
        output out
    );

endinterface

// File: rtl/register16.sv
// 16-bit storage word with load enable and asynchronous clear.
// One of these backs each location of ram8.
module register16
    import hack_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  word_t in,
    input  logic  load,
    output word_t out
);

    // Capture in on a loaded edge; reset clears without a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= WORD_RESET;
        end else if (load) begin
            out <= in;
        end
    end

endmodule

// File: rtl/ram8.sv
// Eight-word, 16-bit RAM: synchronous write, combinational read, shared address.
// Define RAM8_WRITE_BYPASS_EN to forward write data to out in the write cycle.
module ram8
    import hack_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = RAM8_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    ram8_if.slave       bus
);

    logic [DEPTH-1:0] wr_en;
    logic [WIDTH-1:0] words [DEPTH];
    logic [WIDTH-1:0] rd_word;

    // One-hot write decoder; all enables low when load is low.
    always_comb begin
        wr_en = '0;
        for (int k = 0; k < DEPTH; k++) begin
            wr_en[k] = bus.load && (bus.address == ram8_addr_t'(k));
        end
    end

    register16 reg0 (
        .clk   (clk),
        .reset (reset),
        .in    (bus.in),
        .load  (wr_en[0]),
        .out   (words[0])
    );

    register16 reg1 (
        .clk   (clk),
        .reset (reset),
        .in    (bus.in),
        .load  (wr_en[1]),
        .out   (words[1])
    );

    register16 reg2 (
        .clk   (clk),
        .reset (reset),
        .in    (bus.in),
        .load  (wr_en[2]),
        .out   (words[2])
    );

    register16 reg3 (
        .clk   (clk),
        .reset (reset),
        .in    (bus.in),
        .load  (wr_en[3]),
        .out   (words[3])
    );

    register16 reg4 (
        .clk   (clk),
        .reset (reset),
        .in    (bus.in),
        .load  (wr_en[4]),
        .out   (words[4])
    );

    register16 reg5 (
        .clk   (clk),
        .reset (reset),
        .in    (bus.in),
        .load  (wr_en[5]),
        .out   (words[5])
    );

    register16 reg6 (
        .clk   (clk),
        .reset (reset),
        .in    (bus.in),
        .load  (wr_en[6]),
        .out   (words[6])
    );

    register16 reg7 (
        .clk   (clk),
        .reset (reset),
        .in    (bus.in),
        .load  (wr_en[7]),
        .out   (words[7])
    );

    // Read mux: the addressed stored word.
    always_comb begin
        rd_word = words[bus.address];
    end

`ifdef RAM8_WRITE_BYPASS_EN
    // Write-through: show incoming data during a write; gated off in reset.
    always_comb begin
        bus.out = rd_word;
        if (!reset && bus.load) begin
            bus.out = bus.in;
        end
    end
`else
    // Storage-only read: old data until the capturing edge.
    always_comb begin
        bus.out = rd_word;
    end
`endif

endmodule
